layernorm_stats: RTL and testbench
==================================

Name: layernorm_stats

Overview:
Upstream stage of the layernorm FIFO. It accepts one vector of VEC_LEN signed elements over a valid/ready stream and forwards every accepted element into the FIFO write port. In parallel it accumulates the sum and the sum of squares. At end of vector it emits the mean and variance on a valid/ready stats port, so the downstream normalize stage can consume FIFO data with the stats already known.

Parameters:
WIDTH, 8, element width in bits (signed two's complement)
VEC_LEN, 16, elements per vector; must be a power of two and at least 2
LOG2_LEN, $clog2(VEC_LEN), derived; shift amount for the divide

Ports:
clk  input  1  clock
rstn  input  1  reset, asynchronous, active-low
in_valid  input  1  element valid
in_ready  output  1  element accepted when in_valid && in_ready
in_data  input  WIDTH  signed element
in_last  input  1  marks the final element of a vector
fifo_wr_en  output  1  FIFO write enable
fifo_din  output  WIDTH  FIFO write data
fifo_full  input  1  FIFO full flag
stat_valid  output  1  mean/var valid
stat_ready  input  1  stats consumer ready
stat_mean  output  WIDTH  signed mean
stat_var  output  2*WIDTH  unsigned variance
err_len  output  1  sticky length-mismatch flag

Behaviour:
- Reset values: all outputs 0; state ACCUM; accumulators and element count 0.
- Accumulator widths:
  - sum: signed WIDTH+LOG2_LEN
  - sumsq: unsigned 2*WIDTH+LOG2_LEN
  - no overflow is possible by construction.
- in_ready = (state==ACCUM) && !fifo_full. This is combinational, with no dependence on in_valid.
- Accept cycle (in_valid && in_ready):
  - fifo_wr_en=1 and fifo_din=in_data in the same cycle, combinational pass-through. The FIFO therefore never sees a write while full.
  - sum += in_data; sumsq += in_data*in_data; cnt++.
- End of vector:
  - Triggered by accepting an element with in_last=1, or by accepting element number VEC_LEN.
  - If in_last and cnt+1 != VEC_LEN, err_len sets to 1 and stays set until reset. The vector still closes.
  - Go to FINAL.
- FINAL (1 cycle):
  - mean_r = sum >>> LOG2_LEN (arithmetic, floor toward -inf), truncated to WIDTH.
  - ex2_r = sumsq >> LOG2_LEN.
  - Go to VAR.
- VAR (1 cycle):
  - v = ex2_r - mean_r*mean_r.
  - If v<0, stat_var=0 (clamp); otherwise stat_var=v, truncated to 2*WIDTH.
  - stat_mean=mean_r. Set stat_valid=1. Go to HOLD.
- HOLD:
  - stat_valid, stat_mean and stat_var are held stable until stat_valid && stat_ready.
  - On that handshake: stat_valid=0, clear sum/sumsq/cnt, go to ACCUM. The next element can be accepted in the following cycle.
- Latency: last element accepted in cycle t gives stat_valid=1 in cycle t+2. in_ready=0 from t+1 until the stats handshake completes.
- Boundary conditions:
  - fifo_full asserted mid-vector stalls input only; accumulation resumes on deassert with no element lost.
  - Reset mid-vector or in HOLD discards partial state immediately. Outputs return to reset values.

Optional Feature:
LN_STATS_RMS_EN
- Defined: RMSNorm mode. stat_mean is forced to 0, stat_var = ex2_r (E[x^2]) with no subtraction or clamp, and the sum accumulator is removed. Latency is unchanged (t+2).
- Undefined: full layernorm statistics as described above.

Decomposition:
- Package ln_pkg holds:
  - the FSM state enum (ACCUM, FINAL, VAR, HOLD)
  - width-derivation functions for SUM_W, SQ_W and VAR_W
  - the shared element typedef used with the FIFO.
- One sub-module is natural: ln_stats_acc, holding the sum/sumsq/count registers with clear and accumulate enables. The FSM and the VAR arithmetic stay in the top.

Test Plan:
- WIDTH=8, VEC_LEN=4; inputs 1,2,3,4 with in_last on 4, stat_ready=1 -> four FIFO writes of 1,2,3,4; stat_mean=2, stat_var=3 two cycles after the last accept.
- Inputs -1,-2,-3,-4 -> sum -10 gives stat_mean=-3 (floor); ex2=7, 7-9<0 -> stat_var=0.
- fifo_full high for 3 cycles after the 2nd element of 5,5,5,5 -> in_ready=0 and fifo_wr_en=0 during the stall; final stat_mean=5, stat_var=0; exactly 4 writes.
- stat_ready held low 10 cycles -> stat_valid and values stable, in_ready=0 throughout; a second vector is accepted only after the handshake.
- in_last on the 3rd element (VEC_LEN=4) -> err_len=1 and stays set, stats emitted; a following correct vector still gives correct stats.
- rstn asserted after 2 elements -> outputs 0 immediately; a subsequent vector 1,2,3,4 gives mean 2, var 3. With LN_STATS_RMS_EN defined, the same vector gives mean 0, var 7.

Source files
------------

// File: rtl/ln_pkg.sv
// rtl/ln_pkg.sv - shared FSM state, element type and width helpers for layernorm_stats
//
// Purpose: common definitions imported by ln_stats_acc and layernorm_stats.
// Ports:   none (package).
// Config:  LN_STATS_RMS_EN selects RMSNorm statistics in the users of this package.
package ln_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    FINAL = 2'd1,
    VAR   = 2'd2,
    HOLD  = 2'd3
  } ln_state_t;

  localparam int LN_ELEM_W = 8;

  // Element as it travels through the layernorm FIFO.
  typedef logic signed [LN_ELEM_W-1:0] ln_elem_t;

  // Signed running sum: element width plus one bit per doubling of the vector.
  function automatic int sum_w(input int width, input int log2_len);
    return width + log2_len;
  endfunction

  // Unsigned sum of squares.
  function automatic int sq_w(input int width, input int log2_len);
    return 2 * width + log2_len;
  endfunction

  // Variance / E[x^2] width.
  function automatic int var_w(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/ln_stats_acc.sv
// rtl/ln_stats_acc.sv - sum, sum-of-squares and element count registers for layernorm_stats
//
// Purpose: accumulates one vector's statistics; clr empties all registers, acc_en adds din.
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   clr              clear sum/sumsq/cnt (has priority over acc_en)
//   acc_en           add din into the accumulators and bump cnt
//   din              signed element
//   sum              signed running sum (absent when LN_STATS_RMS_EN is defined)
//   sumsq            unsigned running sum of squares
//   cnt              elements accumulated so far
// Config: LN_STATS_RMS_EN removes the sum accumulator.
module ln_stats_acc
  import ln_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int LOG2_LEN = 4,
  parameter int CNT_W    = LOG2_LEN + 1,
  localparam int SUM_W   = sum_w(WIDTH, LOG2_LEN),
  localparam int SQ_W    = sq_w(WIDTH, LOG2_LEN)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    clr,
  input  logic                    acc_en,
  input  logic signed [WIDTH-1:0] din,
`ifndef LN_STATS_RMS_EN
  output logic signed [SUM_W-1:0] sum,
`endif
  output logic [SQ_W-1:0]         sumsq,
  output logic [CNT_W-1:0]        cnt
);

  // The square of a two's complement value is never negative, so the
  // 2*WIDTH-bit product can be zero-extended into the unsigned accumulator.
  logic signed [2*WIDTH-1:0] sq;
  assign sq = din * din;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
`ifndef LN_STATS_RMS_EN
      sum   <= '0;
`endif
      sumsq <= '0;
      cnt   <= '0;
    end else if (clr) begin
`ifndef LN_STATS_RMS_EN
      sum   <= '0;
`endif
      sumsq <= '0;
      cnt   <= '0;
    end else if (acc_en) begin
`ifndef LN_STATS_RMS_EN
      sum   <= sum + $signed({{LOG2_LEN{din[WIDTH-1]}}, din});
`endif
      sumsq <= sumsq + {{LOG2_LEN{1'b0}}, sq};
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/layernorm_stats.sv
// rtl/layernorm_stats.sv - layernorm mean/variance stage feeding the layernorm FIFO
//
// Purpose: forwards each accepted element to the FIFO write port while accumulating
//          sum and sum of squares; at end of vector presents mean and variance on a
//          valid/ready stats port.
// Ports:
//   clk, rstn                         clock, asynchronous active-low reset
//   in_valid/in_ready/in_data/in_last element stream
//   fifo_wr_en/fifo_din/fifo_full     FIFO write port
//   stat_valid/stat_ready             stats handshake
//   stat_mean                         signed mean, floor(sum / VEC_LEN)
//   stat_var                          unsigned variance, clamped at 0
//   err_len                           sticky: in_last seen on a short vector
// Config: `define LN_STATS_RMS_EN for RMSNorm mode (stat_mean=0, stat_var=E[x^2]).
module layernorm_stats
  import ln_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int VEC_LEN  = 16,
  parameter int LOG2_LEN = $clog2(VEC_LEN)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_data,
  input  logic                    in_last,
  output logic                    fifo_wr_en,
  output logic signed [WIDTH-1:0] fifo_din,
  input  logic                    fifo_full,
  output logic                    stat_valid,
  input  logic                    stat_ready,
  output logic signed [WIDTH-1:0] stat_mean,
  output logic [2*WIDTH-1:0]      stat_var,
  output logic                    err_len
);

  localparam int SUM_W = sum_w(WIDTH, LOG2_LEN);
  localparam int SQ_W  = sq_w(WIDTH, LOG2_LEN);
  localparam int VAR_W = var_w(WIDTH);
  localparam int CNT_W = LOG2_LEN + 1;

  ln_state_t state_q, state_d;

  logic             accept;
  logic             last_elem;
  logic             stat_hs;
  logic             acc_clr;
  logic [SQ_W-1:0]  sumsq;
  logic [CNT_W-1:0] cnt;
  logic [VAR_W-1:0] ex2_r;
  logic             unused_lsb;

`ifndef LN_STATS_RMS_EN
  logic signed [SUM_W-1:0]   sum;
  logic signed [WIDTH-1:0]   mean_r;
  logic signed [2*WIDTH-1:0] mean_sq;
  logic signed [VAR_W:0]     var_full;
`endif

  assign in_ready   = (state_q == ACCUM) && !fifo_full;
  assign accept     = in_valid && in_ready;
  assign fifo_wr_en = accept;
  assign fifo_din   = accept ? in_data : '0;

  // A vector closes on an explicit in_last or on its VEC_LEN-th element.
  assign last_elem  = in_last || (cnt == CNT_W'(VEC_LEN - 1));

  // Stats are visible from the VAR cycle on, so a ready consumer can take
  // them in the same cycle they first appear.
  assign stat_valid = (state_q == VAR) || (state_q == HOLD);
  assign stat_hs    = stat_valid && stat_ready;

  ln_stats_acc #(
    .WIDTH    (WIDTH),
    .LOG2_LEN (LOG2_LEN),
    .CNT_W    (CNT_W)
  ) u_acc (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (acc_clr),
    .acc_en (accept),
    .din    (in_data),
`ifndef LN_STATS_RMS_EN
    .sum    (sum),
`endif
    .sumsq  (sumsq),
    .cnt    (cnt)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_clr = 1'b0;
    case (state_q)
      ACCUM: begin
        if (accept && last_elem) begin
          state_d = FINAL;
        end
      end
      FINAL: begin
        state_d = VAR;
      end
      VAR, HOLD: begin
        if (stat_hs) begin
          state_d = ACCUM;
          acc_clr = 1'b1;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_len <= 1'b0;
    end else if (accept && in_last && (cnt != CNT_W'(VEC_LEN - 1))) begin
      err_len <= 1'b1;
    end
  end

  // Dividing by a power of two is a shift; slicing the top bits of sum is the
  // arithmetic shift (floor toward -inf) already truncated to WIDTH.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ex2_r  <= '0;
`ifndef LN_STATS_RMS_EN
      mean_r <= '0;
`endif
    end else if (state_q == FINAL) begin
      ex2_r  <= sumsq[SQ_W-1:LOG2_LEN];
`ifndef LN_STATS_RMS_EN
      mean_r <= sum[SUM_W-1:LOG2_LEN];
`endif
    end
  end

`ifdef LN_STATS_RMS_EN
  assign unused_lsb = ^sumsq[LOG2_LEN-1:0];
  assign stat_mean  = '0;
  assign stat_var   = stat_valid ? ex2_r : '0;
`else
  assign unused_lsb = ^{sum[LOG2_LEN-1:0], sumsq[LOG2_LEN-1:0]};

  // One extra bit keeps the sign of E[x^2] - mean^2 so it can be clamped.
  assign mean_sq  = mean_r * mean_r;
  assign var_full = $signed({1'b0, ex2_r}) - $signed({mean_sq[2*WIDTH-1], mean_sq});

  assign stat_mean = stat_valid ? mean_r : '0;
  assign stat_var  = (!stat_valid || var_full[VAR_W]) ? '0 : var_full[VAR_W-1:0];
`endif

endmodule

// File: tb/tb_layernorm_stats.sv
// tb/tb_layernorm_stats.sv - scoreboard testbench for layernorm_stats
module tb_layernorm_stats;
  import ln_pkg::*;

  localparam int VEC_LEN = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  ln_elem_t    in_data;
  logic        in_last;
  logic        fifo_wr_en;
  ln_elem_t    fifo_din;
  logic        fifo_full;
  logic        stat_valid;
  logic        stat_ready;
  ln_elem_t    stat_mean;
  logic [15:0] stat_var;
  logic        err_len;

  layernorm_stats #(.WIDTH(8), .VEC_LEN(VEC_LEN)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .fifo_full  (fifo_full),
    .stat_valid (stat_valid),
    .stat_ready (stat_ready),
    .stat_mean  (stat_mean),
    .stat_var   (stat_var),
    .err_len    (err_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mean;
    int vr;
    bit err;
  } stat_t;

  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    wr_count = 0;
  int    exp_fifo[$];
  int    exp_lat[$];
  stat_t exp_stats[$];
  int    cur_vec[$];
  bit    exp_err = 0;
  bit    rnd_full = 0;
  bit    rnd_ready = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference statistics straight from the definition: floor mean over VEC_LEN,
  // E[x^2] - mean^2 clamped at zero (or E[x^2] alone in RMSNorm mode).
  function automatic void model(input int v[$], output int mean, output int vr);
    int s = 0;
    int sq = 0;
    int ex2;
    foreach (v[i]) begin
      s  += v[i];
      sq += v[i] * v[i];
    end
    ex2  = sq / VEC_LEN;
    mean = (s >= 0) ? s / VEC_LEN : -((-s + VEC_LEN - 1) / VEC_LEN);
`ifdef LN_STATS_RMS_EN
    mean = 0;
    vr   = ex2;
`else
    vr = ex2 - mean * mean;
    if (vr < 0) vr = 0;
`endif
  endfunction

  task automatic send_elem(input int d, input bit last);
    int    waited = 0;
    bit    ok = 0;
    stat_t st;
    in_valid = 1'b1;
    in_data  = d[7:0];
    in_last  = last;
    exp_fifo.push_back(d);
    forever begin
      if (rnd_full) fifo_full = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
      waited++;
      if (waited > 200) break;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: element %0d not accepted within 200 cycles", d);
    end else begin
      cur_vec.push_back(d);
      if (last || cur_vec.size() == VEC_LEN) begin
        if (last && cur_vec.size() != VEC_LEN) exp_err = 1;
        model(cur_vec, st.mean, st.vr);
        st.err = exp_err;
        exp_stats.push_back(st);
        exp_lat.push_back(cyc + 2);
        cur_vec.delete();
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (rnd_full) fifo_full = 1'b0;
  endtask

  task automatic send_vec(input int a, input int b, input int c, input int d);
    send_elem(a, 0);
    send_elem(b, 0);
    send_elem(c, 0);
    send_elem(d, 1);
  endtask

  // Monitor: pops expectations whenever the DUT writes the FIFO or completes a stats handshake.
  initial begin
    bit    prev_v = 0;
    stat_t st;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev_v = 0;
        continue;
      end
      if (fifo_wr_en) begin
        wr_count++;
        if (exp_fifo.size() == 0) begin
          total++;
          bad++;
          $display("FAIL fifo_unexpected: write of %0d with nothing expected", fifo_din);
        end else begin
          chk("fifo_din", fifo_din, exp_fifo.pop_front());
        end
      end
      if (stat_valid && !prev_v) begin
        if (exp_lat.size() == 0) begin
          total++;
          bad++;
          $display("FAIL stat_unexpected: stat_valid rose at cycle %0d", cyc);
        end else begin
          chk("stat_latency", cyc, exp_lat.pop_front());
        end
      end
      if (stat_valid && stat_ready && exp_stats.size() != 0) begin
        st = exp_stats.pop_front();
        chk("stat_mean", stat_mean, st.mean);
        chk("stat_var", stat_var, st.vr);
        chk("err_len", err_len, st.err);
      end
      prev_v = stat_valid;
    end
  end

  // Random backpressure on the stats port.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_ready) stat_ready = ($urandom_range(0, 2) != 0);
    end
  end

  initial begin
    int    n;
    int    w0;
    stat_t held;
    rstn = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    fifo_full = 1'b0;
    stat_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_stat_valid", stat_valid, 0);
    chk("rst_stat_mean", stat_mean, 0);
    chk("rst_stat_var", stat_var, 0);
    chk("rst_err_len", err_len, 0);
    chk("rst_fifo_wr_en", fifo_wr_en, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Basic positive and negative (floor, clamp) vectors.
    send_vec(1, 2, 3, 4);
    repeat (3) @(posedge clk);
    #1;
    send_vec(-1, -2, -3, -4);
    repeat (3) @(posedge clk);
    #1;

    // FIFO full for 3 cycles after the 2nd element.
    w0 = wr_count;
    send_elem(5, 0);
    send_elem(5, 0);
    fifo_full = 1'b1;
    in_valid = 1'b1;
    in_data = 8'sd5;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_wr_en", fifo_wr_en, 0);
      @(posedge clk);
      #1;
    end
    fifo_full = 1'b0;
    send_elem(5, 0);
    send_elem(5, 1);
    chk("stall_writes", wr_count - w0, 4);
    repeat (3) @(posedge clk);
    #1;

    // Stats held while the consumer is not ready; closes on count (no in_last).
    stat_ready = 1'b0;
    send_elem(3, 0);
    send_elem(1, 0);
    send_elem(4, 0);
    send_elem(1, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!stat_valid && n < 50);
    chk("hold_valid_seen", stat_valid, 1);
    held = exp_stats[0];
    in_valid = 1'b1;
    in_data = 8'sd9;
    for (int k = 0; k < 10; k++) begin
      chk("hold_valid", stat_valid, 1);
      chk("hold_mean", stat_mean, held.mean);
      chk("hold_var", stat_var, held.vr);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_wr_en", fifo_wr_en, 0);
      @(posedge clk);
      #1;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    stat_ready = 1'b1;
    @(posedge clk);
    #1;
    send_vec(9, -9, 7, 0);
    repeat (3) @(posedge clk);
    #1;

    // Short vector: in_last on the 3rd element, then a correct vector.
    send_elem(2, 0);
    send_elem(4, 0);
    send_elem(6, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("err_sticky", err_len, 1);
    send_vec(10, 20, 30, 40);
    repeat (3) @(posedge clk);
    #1;

    // Reset after 2 elements.
    send_elem(7, 0);
    send_elem(8, 0);
    rstn = 1'b0;
    #1;
    chk("mid_rst_valid", stat_valid, 0);
    chk("mid_rst_var", stat_var, 0);
    chk("mid_rst_err", err_len, 0);
    chk("mid_rst_wr_en", fifo_wr_en, 0);
    cur_vec.delete();
    exp_err = 0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    send_vec(1, 2, 3, 4);
    repeat (3) @(posedge clk);
    #1;

    // Random vectors with random FIFO stalls, stats backpressure and early in_last.
    rnd_full = 1;
    rnd_ready = 1;
    for (int v = 0; v < 40; v++) begin
      for (int i = 0; i < VEC_LEN; i++) begin
        bit last;
        last = (i == VEC_LEN - 1) ? bit'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0);
        send_elem(int'($urandom_range(0, 255)) - 128, last);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        if (last) break;
      end
    end
    rnd_full = 0;
    rnd_ready = 0;
    fifo_full = 1'b0;
    stat_ready = 1'b1;

    n = 0;
    while (exp_stats.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_stats", exp_stats.size(), 0);
    chk("drain_fifo", exp_fifo.size(), 0);
    chk("drain_lat", exp_lat.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
